hs_rx_buf: RTL and testbench



---
 rtl/hs_rx_buf_if.sv | 23 ++
 rtl/hs_rx_buf.sv | 102 ++++++++++
 tb/tb_hs_rx_buf.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/hs_rx_buf_if.sv
// Signal bundle between the a-side sender / b-side consumer and the hs_rx_buf receiver.
// master drives the request, data and load; slave returns the ack and the buffered word.
interface hs_rx_buf_if #(
  parameter int WIDTH_D = 8
);
  logic               a_req;
  logic [WIDTH_D-1:0] bdata;
  logic               bload;
  logic               b_ack;
  logic [WIDTH_D-1:0] dout;
  logic               bvalid;
  logic [1:0]         bcount;

  modport master (
    output a_req, bdata, bload,
    input  b_ack, dout, bvalid, bcount
  );

  modport slave (
    input  a_req, bdata, bload,
    output b_ack, dout, bvalid, bcount
  );
endinterface

// File: rtl/hs_rx_buf.sv
// Four-phase req/ack receiver in the bclk domain with a 2-entry word buffer drained via bvalid/bload.
// Defining HS_RX_SYNC3_EN lengthens the a_req synchronizer from 2 to 3 flops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | b_ack low; waiting for req_s with room in the buffer
// ST_ACK  | word captured, b_ack high; waiting for req_s to drop
module hs_rx_buf #(
  parameter int WIDTH_D = 8
) (
  input logic      bclk,
  input logic      brst_n,
  hs_rx_buf_if.slave bus
);

`ifdef HS_RX_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [SYNC_N-1:0]  sync_q;
  logic               req_s;
  logic [WIDTH_D-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;
  logic               capture;
  logic               pop;

  assign req_s = sync_q[SYNC_N-1];

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], bus.a_req};
    end
  end

  // Full test uses the pre-pop count so a capture never relies on a same-cycle pop.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s && (count_q != 2'd2)) begin
          state_d = ST_ACK;
          capture = 1'b1;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop     = bus.bload && (count_q != 2'd0);
    count_d = count_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (capture) begin
        mem_q[wr_ptr_q] <= bus.bdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.b_ack  = (state_q == ST_ACK);
  assign bus.dout   = mem_q[rd_ptr_q];
  assign bus.bvalid = (count_q != 2'd0);
  assign bus.bcount = count_q;

endmodule

// File: tb/tb_hs_rx_buf.sv
// Scoreboard bench for hs_rx_buf: directed handshake scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the receiver (honours HS_RX_SYNC3_EN).
module tb_hs_rx_buf;

`ifdef HS_RX_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif

  logic bclk   = 1'b0;
  logic brst_n = 1'b0;

  hs_rx_buf_if #(.WIDTH_D(8)) bus ();

  hs_rx_buf #(.WIDTH_D(8)) dut (
    .bclk   (bclk),
    .brst_n (brst_n),
    .bus    (bus)
  );

  always #5 bclk = ~bclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit rand_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a_req samples delayed by SYNC edges give the synchronized request;
  // the buffer is a queue of at most two words.
  logic [7:0] mq[$];
  logic       m_ack = 1'b0;
  logic       hist [4];
  logic       p_req  = 1'b0;
  logic       p_load = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       reqs;
  bit         cap, do_pop, live = 1'b0;

  always @(negedge bclk) begin
    if (!brst_n) begin
      mq.delete();
      m_ack = 1'b0;
      foreach (hist[k]) hist[k] = 1'b0;
      live = 1'b0;
    end else begin
      if (live) begin
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = p_req;
        reqs    = hist[SYNC];
        do_pop  = p_load && (mq.size() != 0);
        cap     = !m_ack && reqs && (mq.size() < 2);
        m_ack   = m_ack ? reqs : cap;
        if (do_pop) void'(mq.pop_front());
        if (cap) mq.push_back(p_data);
      end
      live = 1'b1;
      chk("b_ack",  32'(bus.b_ack),  32'(m_ack));
      chk("bcount", 32'(bus.bcount), 32'(mq.size()));
      chk("bvalid", 32'(bus.bvalid), 32'(mq.size() != 0));
      if (bus.bload && mq.size() != 0) chk("pop_word", 32'(bus.dout), 32'(mq[0]));
    end
    p_req  = bus.a_req;
    p_load = bus.bload;
    p_data = bus.bdata;
  end

  always @(posedge bclk) begin
    #2;
    if (rand_en) bus.bload = ($urandom_range(0, 2) == 0);
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic wait_ack(input logic val, input int max, input string name);
    int i = 0;
    while (bus.b_ack !== val && i < max) begin
      tick();
      i++;
    end
    chk(name, 32'(bus.b_ack), 32'(val));
  endtask

  task automatic send(input logic [7:0] w);
    bus.bdata = w;
    bus.a_req = 1'b1;
    wait_ack(1'b1, 300, "ack_rise");
    bus.a_req = 1'b0;
    wait_ack(1'b0, 50, "ack_fall");
  endtask

  initial begin
    bus.a_req = 1'b0;
    bus.bdata = 8'h00;
    bus.bload = 1'b0;
    repeat (3) tick();
    chk("rst_ack",    32'(bus.b_ack),  0);
    chk("rst_valid",  32'(bus.bvalid), 0);
    chk("rst_count",  32'(bus.bcount), 0);
    chk("rst_dout",   32'(bus.dout),   0);
    brst_n = 1'b1;
    tick();

    // Request latency with 8'hA5
    bus.bdata = 8'hA5;
    bus.a_req = 1'b1;
    for (int i = 0; i < SYNC; i++) begin
      tick();
      chk("lat_ack_low", 32'(bus.b_ack), 0);
    end
    tick();
    chk("lat_ack_high", 32'(bus.b_ack),  1);
    chk("lat_valid",    32'(bus.bvalid), 1);
    chk("lat_dout",     32'(bus.dout),   'hA5);
    chk("lat_count",    32'(bus.bcount), 1);
    bus.a_req = 1'b0;
    for (int i = 0; i < SYNC; i++) begin
      tick();
      chk("rel_ack_high", 32'(bus.b_ack), 1);
    end
    tick();
    chk("rel_ack_low", 32'(bus.b_ack), 0);
    bus.bload = 1'b1;
    tick();
    bus.bload = 1'b0;
    chk("pop1_valid", 32'(bus.bvalid), 0);
    chk("pop1_count", 32'(bus.bcount), 0);

    // Back-pressure: third word waits until a slot frees
    send(8'h11);
    send(8'h22);
    chk("bp_count_full", 32'(bus.bcount), 2);
    bus.bdata = 8'h33;
    bus.a_req = 1'b1;
    repeat (8) tick();
    chk("bp_no_ack",  32'(bus.b_ack),  0);
    chk("bp_count",   32'(bus.bcount), 2);
    chk("bp_head11",  32'(bus.dout),   'h11);
    bus.bload = 1'b1;
    tick();
    bus.bload = 1'b0;
    chk("bp_head22", 32'(bus.dout), 'h22);
    wait_ack(1'b1, 20, "bp_ack_late");
    chk("bp_count_refill", 32'(bus.bcount), 2);
    bus.a_req = 1'b0;
    wait_ack(1'b0, 20, "bp_ack_fall");
    bus.bload = 1'b1;
    tick();
    chk("bp_head33", 32'(bus.dout), 'h33);
    tick();
    bus.bload = 1'b0;
    chk("bp_drained", 32'(bus.bvalid), 0);

    // Pop on the capture edge at count 1
    send(8'h44);
    bus.bdata = 8'h55;
    bus.a_req = 1'b1;
    repeat (SYNC) tick();
    bus.bload = 1'b1;
    tick();
    bus.bload = 1'b0;
    chk("pc_count", 32'(bus.bcount), 1);
    chk("pc_dout",  32'(bus.dout),   'h55);
    chk("pc_ack",   32'(bus.b_ack),  1);
    bus.a_req = 1'b0;
    wait_ack(1'b0, 20, "pc_ack_fall");
    bus.bload = 1'b1;
    tick();
    bus.bload = 1'b0;

    // Load while empty, then reset while in ACK with two words held
    bus.bload = 1'b1;
    tick();
    bus.bload = 1'b0;
    chk("empty_load_count", 32'(bus.bcount), 0);
    chk("empty_load_valid", 32'(bus.bvalid), 0);
    send(8'h66);
    bus.bdata = 8'h77;
    bus.a_req = 1'b1;
    wait_ack(1'b1, 20, "rst_pre_ack");
    chk("rst_pre_count", 32'(bus.bcount), 2);
    brst_n = 1'b0;
    #1;
    chk("mid_rst_ack",   32'(bus.b_ack),  0);
    chk("mid_rst_valid", 32'(bus.bvalid), 0);
    chk("mid_rst_count", 32'(bus.bcount), 0);
    chk("mid_rst_dout",  32'(bus.dout),   0);
    bus.a_req = 1'b0;
    repeat (2) tick();
    brst_n = 1'b1;
    tick();

    // Random traffic with a random consumer
    rand_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 4)) tick();
      send(8'($urandom));
    end
    rand_en = 1'b0;
    tick();
    bus.bload = 1'b1;
    repeat (4) tick();
    bus.bload = 1'b0;
    tick();
    chk("final_empty", 32'(bus.bcount), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
